// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory-port arbiter.
package mem_arb_pkg;
   typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D} arb_state_e;

   localparam logic        MEMRW_READ   = 1'b1;
   localparam logic        MEMRW_WRITE  = 1'b0;
   localparam logic [31:0] NOP_INSTR    = 32'h00000013;
   localparam int          STARVE_CNT_W = 4;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, load/store and memory-side signals of the arbiter; master = arbiter, slave = environment.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt;
   logic              if_rvalid;
   logic [DATA_W-1:0] if_rdata;
   logic              d_req;
   logic              d_memrw;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_gnt;
   logic              d_rvalid;
   logic [DATA_W-1:0] d_rdata;
   logic              mem_req;
   logic              mem_memrw;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ready;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      input  if_req, if_addr, d_req, d_memrw, d_addr, d_wdata, mem_ready, mem_rdata,
      output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
             mem_req, mem_memrw, mem_addr, mem_wdata
   );

   modport slave (
      output if_req, if_addr, d_req, d_memrw, d_addr, d_wdata, mem_ready, mem_rdata,
      input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
             mem_req, mem_memrw, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_arb_priority.sv
// Winner select for the shared memory port: data first, unless fetch has waited STARVE_MAX data grants.
module mem_arb_priority
   import mem_arb_pkg::*;
#(
   parameter int STARVE_MAX = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic idle_i,
   input  logic if_req_i,
   input  logic d_req_i,
   output logic sel_if_o,
   output logic sel_d_o
);
   localparam logic [STARVE_CNT_W-1:0] STARVE_LIM = STARVE_CNT_W'(STARVE_MAX);

   logic [STARVE_CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      sel_if_o = if_req_i && (!d_req_i || (cnt_q == STARVE_LIM));
      sel_d_o  = d_req_i && !sel_if_o;
      cnt_d    = cnt_q;
      // Count only decisions taken in IDLE; a data win while fetch waits is one starvation step.
      if (idle_i) begin
         if (!if_req_i || sel_if_o) begin
            cnt_d = '0;
         end else if (sel_d_o) begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one memory port between fetch and load/store; one access outstanding at a time.
// Optional MEM_TIMEOUT_EN adds a BUSY watchdog and the mem_err output.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
`ifdef MEM_TIMEOUT_EN
   ,parameter int TIMEOUT_CYCLES = 64
`endif
) (
   input  logic                clk,
   input  logic                rst,
   mem_port_arbiter_if.master  bus
`ifdef MEM_TIMEOUT_EN
   ,output logic               mem_err
`endif
);
   arb_state_e        state_q, state_d;
   logic              idle, sel_if, sel_d;
   logic              if_gnt_q, if_gnt_d, d_gnt_q, d_gnt_d;
   logic              if_rvalid_q, if_rvalid_d, d_rvalid_q, d_rvalid_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
   logic              mem_req_q, mem_req_d, mem_memrw_q, mem_memrw_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
`ifdef MEM_TIMEOUT_EN
   localparam int               WD_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
   logic [WD_W-1:0]             wdog_q, wdog_d;
   logic                        mem_err_q, mem_err_d;
`endif

   assign idle = (state_q == IDLE);

   mem_arb_priority #(.STARVE_MAX(STARVE_MAX)) u_prio (
      .clk      (clk),
      .rst      (rst),
      .idle_i   (idle),
      .if_req_i (bus.if_req),
      .d_req_i  (bus.d_req),
      .sel_if_o (sel_if),
      .sel_d_o  (sel_d)
   );

   always_comb begin
      state_d     = state_q;
      if_gnt_d    = 1'b0;
      d_gnt_d     = 1'b0;
      if_rvalid_d = 1'b0;
      d_rvalid_d  = 1'b0;
      if_rdata_d  = if_rdata_q;
      d_rdata_d   = d_rdata_q;
      mem_req_d   = mem_req_q;
      mem_memrw_d = mem_memrw_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
`ifdef MEM_TIMEOUT_EN
      wdog_d      = wdog_q;
      mem_err_d   = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            mem_req_d = 1'b0;
            if (sel_d) begin
               state_d     = BUSY_D;
               mem_req_d   = 1'b1;
               mem_memrw_d = bus.d_memrw;
               mem_addr_d  = bus.d_addr;
               mem_wdata_d = bus.d_wdata;
               d_gnt_d     = 1'b1;
`ifdef MEM_TIMEOUT_EN
               wdog_d      = '0;
`endif
            end else if (sel_if) begin
               state_d     = BUSY_IF;
               mem_req_d   = 1'b1;
               mem_memrw_d = MEMRW_READ;
               mem_addr_d  = bus.if_addr;
               mem_wdata_d = '0;
               if_gnt_d    = 1'b1;
`ifdef MEM_TIMEOUT_EN
               wdog_d      = '0;
`endif
            end
         end
         BUSY_IF: begin
            if (bus.mem_ready) begin
               state_d     = IDLE;
               mem_req_d   = 1'b0;
               if_rvalid_d = 1'b1;
               if_rdata_d  = bus.mem_rdata;
            end
`ifdef MEM_TIMEOUT_EN
            else if (wdog_q == WD_LAST) begin
               state_d     = IDLE;
               mem_req_d   = 1'b0;
               if_rvalid_d = 1'b1;
               if_rdata_d  = DATA_W'(NOP_INSTR);
               mem_err_d   = 1'b1;
            end else begin
               wdog_d = wdog_q + 1'b1;
            end
`endif
         end
         BUSY_D: begin
            // Stores complete with an rvalid ack but leave the load-data register alone.
            if (bus.mem_ready) begin
               state_d    = IDLE;
               mem_req_d  = 1'b0;
               d_rvalid_d = 1'b1;
               if (mem_memrw_q == MEMRW_READ) begin
                  d_rdata_d = bus.mem_rdata;
               end
            end
`ifdef MEM_TIMEOUT_EN
            else if (wdog_q == WD_LAST) begin
               state_d    = IDLE;
               mem_req_d  = 1'b0;
               d_rvalid_d = 1'b1;
               d_rdata_d  = '0;
               mem_err_d  = 1'b1;
            end else begin
               wdog_d = wdog_q + 1'b1;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         if_gnt_q    <= 1'b0;
         d_gnt_q     <= 1'b0;
         if_rvalid_q <= 1'b0;
         d_rvalid_q  <= 1'b0;
         if_rdata_q  <= '0;
         d_rdata_q   <= '0;
         mem_req_q   <= 1'b0;
         mem_memrw_q <= MEMRW_WRITE;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
`ifdef MEM_TIMEOUT_EN
         wdog_q      <= '0;
         mem_err_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         if_gnt_q    <= if_gnt_d;
         d_gnt_q     <= d_gnt_d;
         if_rvalid_q <= if_rvalid_d;
         d_rvalid_q  <= d_rvalid_d;
         if_rdata_q  <= if_rdata_d;
         d_rdata_q   <= d_rdata_d;
         mem_req_q   <= mem_req_d;
         mem_memrw_q <= mem_memrw_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
`ifdef MEM_TIMEOUT_EN
         wdog_q      <= wdog_d;
         mem_err_q   <= mem_err_d;
`endif
      end
   end

   assign bus.if_gnt    = if_gnt_q;
   assign bus.d_gnt     = d_gnt_q;
   assign bus.if_rvalid = if_rvalid_q;
   assign bus.d_rvalid  = d_rvalid_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.d_rdata   = d_rdata_q;
   assign bus.mem_req   = mem_req_q;
   assign bus.mem_memrw = mem_memrw_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
`ifdef MEM_TIMEOUT_EN
   assign mem_err       = mem_err_q;
`endif
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the core's single unified instruction/data memory port between the instruction-fetch unit and the load/store path. It sits between fetch/LSU and memory.
- Per-transaction FSM with request/grant/valid handshakes.
- Data accesses have priority; a starvation counter guarantees fetch progress.
- Memory latency is variable and signalled by mem_ready.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
STARVE_MAX, 4, consecutive data grants allowed while fetch waits (1..15)
TIMEOUT_CYCLES, 64, watchdog limit; used only with MEM_TIMEOUT_EN

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
if_req  in  1  fetch request; held until if_gnt
if_addr  in  ADDR_W  fetch address
if_gnt  out  1  one-cycle grant pulse to fetch
if_rvalid  out  1  one-cycle fetch-data-valid pulse
if_rdata  out  DATA_W  fetched instruction, registered
d_req  in  1  data request; held until d_gnt
d_memrw  in  1  1=read, 0=write (same polarity as control memrw)
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_gnt  out  1  one-cycle grant pulse to data
d_rvalid  out  1  one-cycle completion pulse (read data or write ack)
d_rdata  out  DATA_W  load data, registered
mem_req  out  1  memory request, held until mem_ready
mem_memrw  out  1  1=read, 0=write
mem_addr  out  ADDR_W  registered address
mem_wdata  out  DATA_W  registered store data
mem_ready  in  1  memory completes the current access this cycle
mem_rdata  in  DATA_W  read data, valid with mem_ready

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0; starvation counter 0. Any in-flight access is abandoned and no rvalid is issued.
- States: IDLE, BUSY_IF, BUSY_D.
- IDLE, cycle N: sample requests and pick a winner.
  - Winner is data if d_req=1, unless fetch is being starved (see below).
  - On the edge ending N: go to BUSY_x; mem_req=1.
  - mem_addr, mem_memrw and mem_wdata are registered from the winner. Fetch forces memrw=1 and wdata=0.
  - Winner's gnt pulses in cycle N+1.
- No request in IDLE: outputs unchanged except mem_req=0.
- BUSY_x: hold mem_req and all mem_* outputs stable until mem_ready=1 is sampled.
  - On that edge: go to IDLE; mem_req=0; x_rvalid pulses for one cycle.
  - For reads, x_rdata is registered from mem_rdata.
  - For writes, d_rdata is unchanged.
- mem_ready is ignored while mem_req=0.
- Minimum latency:
  - req sampled at N → gnt at N+1 → mem_ready at N+1 → rvalid at N+2.
  - The next access starts at N+2 or later, one IDLE cycle minimum between accesses.
- Starvation counter (width 4):
  - Increments on a data grant while if_req=1.
  - Clears on a fetch grant, or when if_req=0 in IDLE.
  - When count==STARVE_MAX and both requests are present, fetch wins.
- A requester may change its req/addr after its gnt; the arbiter has already latched them.
- Requests are never dropped: a losing request stays pending and is re-evaluated in the next IDLE cycle.
- Grant and rvalid of different requesters never overlap, because only one access is outstanding.

Optional Feature:
MEM_TIMEOUT_EN:
- Defined:
  - A watchdog counts BUSY cycles. On reaching TIMEOUT_CYCLES without mem_ready, the access aborts: state→IDLE, mem_req=0, x_rvalid pulses.
  - Extra output mem_err (1 bit) pulses together with that rvalid.
  - if_rdata is set to 32'h00000013 (NOP). d_rdata is set to 0.
  - The watchdog clears on every grant.
- Undefined: no watchdog, no mem_err port; BUSY waits indefinitely.

Decomposition:
Package mem_arb_pkg:
- State enum {IDLE, BUSY_IF, BUSY_D}.
- MEMRW_READ=1, MEMRW_WRITE=0.
- NOP_INSTR=32'h00000013.
- STARVE_CNT_W=4.

Sub-module mem_arb_priority (combinational winner select plus the starvation counter register). The top level holds the FSM, the datapath registers and the watchdog.

Test Plan:
- Fetch only: if_req=1, if_addr=0x100, mem_ready=1 one cycle after mem_req, mem_rdata=0x00500093 → if_gnt at N+1, if_rvalid at N+2, if_rdata=0x00500093, mem_memrw=1.
- Store: d_req=1, d_memrw=0, d_addr=0x200, d_wdata=0xDEADBEEF, mem_ready after 3 wait cycles → mem_* stable for 4 cycles, d_rvalid one pulse, d_rdata unchanged.
- Contention and starvation: if_req=1 and d_req=1 held continuously, STARVE_MAX=4 → grant order D,D,D,D,IF,D,D,D,D,IF.
- Simultaneous single requests: both asserted once at count 0 → data granted first, fetch second, no request lost.
- Reset mid-access: assert rst while in BUSY_D → mem_req=0 immediately (async), no d_rvalid; a fresh fetch after release completes normally.
- MEM_TIMEOUT_EN with TIMEOUT_CYCLES=8 and mem_ready held 0 → after 8 BUSY cycles: if_rvalid=1, mem_err=1, if_rdata=0x00000013.
